// File: rtl/constraint_check_arbiter.sv
// constraint_check_arbiter
// Round-robin front end for a single shared combinational constraint checker.
// One candidate is in flight at a time: IDLE accepts, ISSUE drives the
// checker for exactly one cycle, RESP returns the registered verdict to the
// winner. Pass/fail totals are kept in saturating counters.
module constraint_check_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [DW-1:0]        chk_data,
  output logic                 chk_valid,
  input  logic                 chk_pass,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_pass,
  input  logic [NREQ-1:0]      rsp_ready,
  input  logic                 cnt_clr,
  output logic [CNTW-1:0]      pass_cnt,
  output logic [CNTW-1:0]      fail_cnt,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                     state, state_nxt;
  logic [NREQ-1:0][DW-1:0]    req_lanes;
  logic [IW-1:0]              rr_ptr, gnt_idx, pick_idx;
  logic                       pick_vld;
  logic                       hs;
  logic                       rsp_done;
  logic [DW-1:0]              cand;

  // Packed per-lane view: lane i sits at bits [i*DW +: DW]
  assign req_lanes = req_data;

  assign hs       = (state == IDLE) && pick_vld;
  assign rsp_done = (state == RESP) && rsp_ready[gnt_idx];

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    logic [IW:0] idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!pick_vld && req_valid[idx[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = idx[IW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept, one checker cycle, then hold until the winner takes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready[gnt_idx]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready forced low while reset is held
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    chk_valid = 1'b0;
    chk_data  = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (pick_vld && rst_n) req_ready[pick_idx] = 1'b1;
      ISSUE:   begin
        chk_valid = 1'b1;
        chk_data  = cand;
      end
      RESP:    rsp_valid[gnt_idx] = 1'b1;
      default: ;
    endcase
  end

  // Candidate/grant capture on handshake, verdict capture in ISSUE,
  // pointer advances past the winner only once its response is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      rsp_pass <= 1'b0;
    end else begin
      if (hs) begin
        cand    <= req_lanes[pick_idx];
        gnt_idx <= pick_idx;
      end
      if (state == ISSUE) rsp_pass <= chk_pass;
      if (rsp_done)
        rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // Saturating statistics; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (cnt_clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (state == ISSUE) begin
      if (chk_pass) begin
        if (pass_cnt != CMAX) pass_cnt <= pass_cnt + CNTW'(1);
      end else begin
        if (fail_cnt != CMAX) fail_cnt <= fail_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_constraint_check_arbiter.sv
// tb_constraint_check_arbiter
// Scenario tasks against a transaction-level model: expected grant is the
// first valid requester from the model pointer, verdict is the checker
// function of the granted data, counters are clamped integers.
module tb_constraint_check_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int CNTW = 4;
  localparam int MAXC = (1 << CNTW) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_data;
  logic [DW-1:0]       chk_data;
  logic                chk_valid;
  logic                chk_pass;
  logic [NREQ-1:0]     rsp_valid;
  logic                rsp_pass;
  logic [NREQ-1:0]     rsp_ready;
  logic                cnt_clr;
  logic [CNTW-1:0]     pass_cnt;
  logic [CNTW-1:0]     fail_cnt;
  logic                busy;

  int errors = 0;
  int checks = 0;
  int m_rr, m_pass, m_fail;

  constraint_check_arbiter #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .chk_data(chk_data), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .rsp_valid(rsp_valid), .rsp_pass(rsp_pass), .rsp_ready(rsp_ready),
    .cnt_clr(cnt_clr), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Checker model: odd candidates satisfy the constraint
  assign chk_pass = chk_data[0];

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] m;
    m = '0;
    if (g >= 0) m[g] = 1'b1;
    return m;
  endfunction

  task automatic model_count(input logic p);
    if (p) m_pass = (m_pass < MAXC) ? m_pass + 1 : m_pass;
    else   m_fail = (m_fail < MAXC) ? m_fail + 1 : m_fail;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0; m_pass = 0; m_fail = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ready_busy: got %b/%b want 0/0", req_ready, busy);
    end
    checks++;
    if ({rsp_valid, rsp_pass, chk_valid, chk_data} !== '0) begin
      errors++; $display("FAIL reset_rsp_chk: got %b %b %b %h want zeros", rsp_valid, rsp_pass, chk_valid, chk_data);
    end
    checks++;
    if (pass_cnt !== '0 || fail_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pass_cnt, fail_cnt);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0; m_pass = 0; m_fail = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b ready=%b want 0/0", busy, req_ready);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    req_data = '0;
    req_data[0 +: DW] = 32'h0000_00A5;
    req_valid = 4'b0001; rsp_ready = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_req_ready: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (chk_valid !== 1'b1 || chk_data !== 32'h0000_00A5) begin
      errors++; $display("FAIL single_chk: got v=%b d=%h want 1/000000a5", chk_valid, chk_data);
    end
    model_count(1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_pass !== 1'b1) begin
      errors++; $display("FAIL single_rsp: got %b/%b want 0001/1", rsp_valid, rsp_pass);
    end
    checks++;
    if (pass_cnt !== CNTW'(m_pass) || fail_cnt !== CNTW'(m_fail)) begin
      errors++; $display("FAIL single_cnt: got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, m_pass, m_fail);
    end
    m_rr = 1;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got rsp=%b busy=%b want 0000/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    int g;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
    req_valid = '1; rsp_ready = '1;
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      g = exp_grant(req_valid, m_rr);
      d = req_data[g*DW +: DW];
      #1;
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", t, req_ready, onehot(g));
      end
      @(negedge clk); #1;
      checks++;
      if (chk_valid !== 1'b1 || chk_data !== d || req_ready !== '0) begin
        errors++; $display("FAIL rr_issue%0d: got v=%b d=%h rdy=%b want 1/%h/0000", t, chk_valid, chk_data, req_ready, d);
      end
      model_count(d[0]);
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== onehot(g) || rsp_pass !== d[0]) begin
        errors++; $display("FAIL rr_rsp%0d: got %b/%b want %b/%b", t, rsp_valid, rsp_pass, onehot(g), d[0]);
      end
      m_rr = (g + 1) % NREQ;
    end
    @(negedge clk);
    req_valid = '0; rsp_ready = '0;
    #1;
    checks++;
    if (pass_cnt !== CNTW'(m_pass) || fail_cnt !== CNTW'(m_fail)) begin
      errors++; $display("FAIL rr_cnt: got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, m_pass, m_fail);
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d;
    do_reset();
    @(negedge clk);
    d = $urandom;
    req_data[2*DW +: DW] = d;
    req_valid = 4'b0100; rsp_ready = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_grant: got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '1;
    req_data[2*DW +: DW] = ~d;
    model_count(d[0]);
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_pass !== d[0]) begin
      errors++; $display("FAIL bp_rsp: got %b/%b want 0100/%b", rsp_valid, rsp_pass, d[0]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) rsp_ready = 4'b0100;
      #1;
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_pass !== d[0] || req_ready !== '0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got rsp=%b p=%b rdy=%b busy=%b want 0100/%b/0000/1",
                           i, rsp_valid, rsp_pass, req_ready, busy, d[0]);
      end
    end
    m_rr = 3;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0 || req_ready !== onehot(exp_grant(req_valid, m_rr))) begin
      errors++; $display("FAIL bp_release: got rsp=%b busy=%b rdy=%b want 0000/0/%b",
                         rsp_valid, busy, req_ready, onehot(exp_grant(req_valid, m_rr)));
    end
    req_valid = '0; rsp_ready = '0;
  endtask

  task automatic test_saturation_clear;
    int g;
    do_reset();
    rsp_ready = '1;
    for (int t = 0; t < 17; t++) begin
      @(negedge clk);
      g = $urandom_range(0, NREQ-1);
      req_valid = onehot(g);
      req_data[g*DW +: DW] = $urandom & 32'hFFFF_FFFE;
      @(negedge clk);
      model_count(1'b0);
      @(negedge clk); #1;
      checks++;
      if (rsp_pass !== 1'b0 || fail_cnt !== CNTW'(m_fail)) begin
        errors++; $display("FAIL sat_fail%0d: got p=%b cnt=%0d want 0/%0d", t, rsp_pass, fail_cnt, m_fail);
      end
      m_rr = (g + 1) % NREQ;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (fail_cnt !== CNTW'(MAXC) || pass_cnt !== '0) begin
      errors++; $display("FAIL sat_final: got %0d/%0d want 0/%0d", pass_cnt, fail_cnt, MAXC);
    end
    req_valid = 4'b0001;
    req_data[0 +: DW] = 32'h1234_5679;
    @(negedge clk);
    req_valid = '0; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    m_pass = 0; m_fail = 0; m_rr = 1;
    #1;
    checks++;
    if (pass_cnt !== '0 || fail_cnt !== '0 || rsp_pass !== 1'b1) begin
      errors++; $display("FAIL clr_wins: got %0d/%0d p=%b want 0/0 p=1", pass_cnt, fail_cnt, rsp_pass);
    end
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid_resp;
    do_reset();
    rsp_ready = '1;
    @(negedge clk);
    req_valid = 4'b0100; req_data[2*DW +: DW] = 32'h2;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rsp_ready = '0;
    req_valid = 4'b0010; req_data[1*DW +: DW] = 32'h11;
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 4'b0010 || pass_cnt !== 4'd1 || fail_cnt !== 4'd1) begin
      errors++; $display("FAIL mid_pre: got %b %0d/%0d want 0010 1/1", rsp_valid, pass_cnt, fail_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_pass, chk_valid, chk_data, pass_cnt, fail_cnt, busy} !== '0) begin
      errors++; $display("FAIL mid_reset_zero: got rdy=%b rsp=%b p=%b cv=%b cd=%h cnt=%0d/%0d busy=%b want zeros",
                         req_ready, rsp_valid, rsp_pass, chk_valid, chk_data, pass_cnt, fail_cnt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0; m_pass = 0; m_fail = 0;
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== onehot(exp_grant(req_valid, m_rr))) begin
      errors++; $display("FAIL mid_rr_ptr: got %b want %b", req_ready, onehot(exp_grant(req_valid, m_rr)));
    end
    req_valid = 4'b1000; req_data[3*DW +: DW] = 32'hCAFE_0003; rsp_ready = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL mid_req3: got %b want 1000", req_ready);
    end
    @(negedge clk); req_valid = '0;
    #1;
    checks++;
    if (chk_valid !== 1'b1 || chk_data !== 32'hCAFE_0003) begin
      errors++; $display("FAIL mid_chk3: got %b/%h want 1/cafe0003", chk_valid, chk_data);
    end
    model_count(1'b1);
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_pass !== 1'b1 || pass_cnt !== CNTW'(m_pass) || fail_cnt !== CNTW'(m_fail)) begin
      errors++; $display("FAIL mid_rsp3: got %b/%b %0d/%0d want 1000/1 %0d/%0d",
                         rsp_valid, rsp_pass, pass_cnt, fail_cnt, m_pass, m_fail);
    end
    m_rr = 0;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_idle_gaps;
    req_valid = '0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
      #1;
      checks++;
      if (chk_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 ||
          pass_cnt !== CNTW'(m_pass) || fail_cnt !== CNTW'(m_fail)) begin
        errors++; $display("FAIL idle%0d: got cv=%b busy=%b rdy=%b cnt=%0d/%0d want 0/0/0000 %0d/%0d",
                           t, chk_valid, busy, req_ready, pass_cnt, fail_cnt, m_pass, m_fail);
      end
    end
  endtask

  task automatic test_random;
    logic [NREQ-1:0] v, gm;
    logic [DW-1:0] d;
    int g, dly;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
      req_valid = v;
      g = exp_grant(v, m_rr);
      gm = onehot(g);
      d = req_data[g*DW +: DW];
      rsp_ready = NREQ'($urandom) & ~gm;
      #1;
      checks++;
      if (req_ready !== gm) begin
        errors++; $display("FAIL rnd_grant%0d: got %b want %b", t, req_ready, gm);
      end
      @(negedge clk);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
      #1;
      checks++;
      if (chk_valid !== 1'b1 || chk_data !== d || req_ready !== '0) begin
        errors++; $display("FAIL rnd_issue%0d: got v=%b d=%h rdy=%b want 1/%h/0000", t, chk_valid, chk_data, req_ready, d);
      end
      model_count(d[0]);
      @(negedge clk);
      dly = $urandom_range(0, 3);
      rsp_ready = (NREQ'($urandom) & ~gm) | ((dly == 0) ? gm : '0);
      #1;
      checks++;
      if (rsp_valid !== gm || rsp_pass !== d[0] || pass_cnt !== CNTW'(m_pass) || fail_cnt !== CNTW'(m_fail)) begin
        errors++; $display("FAIL rnd_rsp%0d: got %b/%b %0d/%0d want %b/%b %0d/%0d",
                           t, rsp_valid, rsp_pass, pass_cnt, fail_cnt, gm, d[0], m_pass, m_fail);
      end
      for (int i = 1; i <= dly; i++) begin
        @(negedge clk);
        rsp_ready = (NREQ'($urandom) & ~gm) | ((i == dly) ? gm : '0);
        #1;
        checks++;
        if (rsp_valid !== gm || rsp_pass !== d[0] || busy !== 1'b1) begin
          errors++; $display("FAIL rnd_hold%0d: got %b/%b busy=%b want %b/%b/1", t, rsp_valid, rsp_pass, busy, gm, d[0]);
        end
      end
      m_rr = (g + 1) % NREQ;
    end
    @(negedge clk);
    req_valid = '0; rsp_ready = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL rnd_end: got busy=%b rdy=%b want 0/0000", busy, req_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '0; cnt_clr = 1'b0;
    m_rr = 0; m_pass = 0; m_fail = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_saturation_clear();
    test_reset_mid_resp();
    test_idle_gaps();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
